// File: rtl/ex_rs2_forward_unit_if.sv
// Bus between the ID/EX pipeline control and the EX-stage Rs2 forward unit.
// Stats outputs exist only when FWD_STATS_EN is defined.
interface ex_rs2_forward_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      Tick;
    logic                      flush;
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic [DATA_WIDTH-1:0]     ex_result;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic [DATA_WIDTH-1:0]     wb_result;
    logic [DATA_WIDTH-1:0]     rs2_fwd_data;
    logic                      rs2_fwd_en;
    logic                      stall;
    logic [1:0]                fwd_sel;
`ifdef FWD_STATS_EN
    logic [15:0]               stall_count;
    logic [15:0]               fwd_count;
`endif

    modport master (
        output Tick, flush, id_valid, id_rs2, id_rs2_data, id_rd,
               id_reg_write, id_mem_read, ex_result, mem_result, wb_result,
        input  rs2_fwd_data, rs2_fwd_en, stall, fwd_sel
`ifdef FWD_STATS_EN
        , input stall_count, fwd_count
`endif
    );

    modport slave (
        input  Tick, flush, id_valid, id_rs2, id_rs2_data, id_rd,
               id_reg_write, id_mem_read, ex_result, mem_result, wb_result,
        output rs2_fwd_data, rs2_fwd_en, stall, fwd_sel
`ifdef FWD_STATS_EN
        , output stall_count, fwd_count
`endif
    );
endinterface

// File: rtl/ex_rs2_forward_unit.sv
// EX-stage Rs2 forwarding control: EX/MEM/WB writer shadow, operand select, load-use stall FSM.
// Define FWD_STATS_EN to add saturating stall/forward Tick counters.
module ex_rs2_forward_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic                   Clock,
    input logic                   Reset,
    ex_rs2_forward_unit_if.slave  bus
);
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
    } entry_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    entry_t shadow_reg  [3];
    entry_t shadow_next [3];
    state_t state_reg, state_next;

    logic [2:0]            match;
    logic                  load_use;
    logic                  stall_int;
    logic [1:0]            sel_int;
    logic [DATA_WIDTH-1:0] data_mux;

    // Index 0 is the youngest writer, so a lower index means fresher data.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            assign match[gi] = shadow_reg[gi].valid & shadow_reg[gi].reg_write &
                               (shadow_reg[gi].rd == bus.id_rs2) &
                               (bus.id_rs2 != '0) & bus.id_valid;
        end
    endgenerate

    always_comb begin
        load_use  = match[EX] & shadow_reg[EX].mem_read;
        stall_int = (state_reg == RUN) & load_use & ~bus.flush;
        sel_int   = 2'b00;
        if (!stall_int) begin
            if (match[EX])       sel_int = 2'b01;
            else if (match[MEM]) sel_int = 2'b10;
            else if (match[WB])  sel_int = 2'b11;
        end
        case (sel_int)
            2'b01:   data_mux = bus.ex_result;
            2'b10:   data_mux = bus.mem_result;
            2'b11:   data_mux = bus.wb_result;
            default: data_mux = bus.id_rs2_data;
        endcase
    end

    assign bus.stall        = stall_int;
    assign bus.rs2_fwd_en   = ~stall_int;
    assign bus.fwd_sel      = sel_int;
    assign bus.rs2_fwd_data = data_mux;

    always_comb begin
        state_next  = state_reg;
        shadow_next = shadow_reg;
        if (bus.Tick) begin
            shadow_next[WB]            = shadow_reg[MEM];
            shadow_next[MEM]           = shadow_reg[EX];
            shadow_next[EX].valid      = bus.id_valid & ~stall_int & ~bus.flush;
            shadow_next[EX].rd         = bus.id_rd;
            shadow_next[EX].reg_write  = bus.id_reg_write;
            shadow_next[EX].mem_read   = bus.id_mem_read;
            case (state_reg)
                RUN:     state_next = stall_int ? STALL : RUN;
                // The load has moved to MEM, so a single bubble is enough.
                STALL:   state_next = RUN;
                default: state_next = RUN;
            endcase
            if (bus.flush) state_next = RUN;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) shadow_reg[i] <= '0;
            state_reg <= RUN;
        end else begin
            shadow_reg <= shadow_next;
            state_reg  <= state_next;
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] stall_count_reg;
    logic [15:0] fwd_count_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stall_count_reg <= '0;
            fwd_count_reg   <= '0;
        end else if (bus.Tick) begin
            if (stall_int && stall_count_reg != 16'hFFFF)
                stall_count_reg <= stall_count_reg + 16'd1;
            if (!stall_int && sel_int != 2'b00 && fwd_count_reg != 16'hFFFF)
                fwd_count_reg <= fwd_count_reg + 16'd1;
        end
    end

    assign bus.stall_count = stall_count_reg;
    assign bus.fwd_count   = fwd_count_reg;
`endif
endmodule

// File: tb/tb_ex_rs2_forward_unit.sv
// Self-checking bench for ex_rs2_forward_unit: directed scenarios then random traffic
// against an instruction-history reference model.
module tb_ex_rs2_forward_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    ex_rs2_forward_unit_if bus ();
    ex_rs2_forward_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed { bit v; bit [4:0] rd; bit rw; bit mr; } ins_t;
    ins_t hist [3];   // what entered EX on the last three Ticks, youngest first
    bit        m_stalled;
    bit        e_stall;
    bit [1:0]  e_sel;
    bit [31:0] e_data;
    int        m_stall_cnt, m_fwd_cnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            pass_count++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_stalled = 0;
        m_stall_cnt = 0;
        m_fwd_cnt = 0;
    endtask

    task automatic model_eval();
        int src;
        src = -1;
        if (bus.id_valid && bus.id_rs2 != 0)
            for (int age = 0; age < 3; age++)
                if (src < 0 && hist[age].v && hist[age].rw && hist[age].rd == bus.id_rs2) src = age;
        e_stall = (src == 0) && hist[0].mr && !bus.flush && !m_stalled;
        e_sel   = (e_stall || src < 0) ? 2'd0 : 2'(src + 1);
        case (e_sel)
            2'd1:    e_data = bus.ex_result;
            2'd2:    e_data = bus.mem_result;
            2'd3:    e_data = bus.wb_result;
            default: e_data = bus.id_rs2_data;
        endcase
    endtask

    task automatic model_tick();
        ins_t n;
        n.v  = bus.id_valid && !e_stall && !bus.flush;
        n.rd = bus.id_rd;
        n.rw = bus.id_reg_write;
        n.mr = bus.id_mem_read;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = n;
        if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
        if (!e_stall && e_sel != 0 && m_fwd_cnt < 65535) m_fwd_cnt++;
        m_stalled = e_stall;
    endtask

    task automatic drive(input bit tick, input bit fl, input bit vld, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit rw, input bit mr, input bit [31:0] rdata);
        bus.Tick = tick; bus.flush = fl; bus.id_valid = vld; bus.id_rs2 = rs2;
        bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_rs2_data = rdata;
        #1;
        model_eval();
        check_val("stall", bus.stall, e_stall);
        check_val("rs2_fwd_en", bus.rs2_fwd_en, !e_stall);
        check_val("fwd_sel", bus.fwd_sel, e_sel);
        check_val("rs2_fwd_data", bus.rs2_fwd_data, e_data);
`ifdef FWD_STATS_EN
        check_val("stall_count", bus.stall_count, m_stall_cnt);
        check_val("fwd_count", bus.fwd_count, m_fwd_cnt);
`endif
    endtask

    task automatic advance();
        @(posedge Clock);
        if (bus.Tick && !Reset) model_tick();
        @(negedge Clock);
    endtask

    task automatic issue(input bit [4:0] rd, input bit rw, input bit mr);
        drive(1, 0, 1, 5'd0, rd, rw, mr, $urandom);
        advance();
    endtask

    task automatic rand_results();
        bus.ex_result  = $urandom;
        bus.mem_result = $urandom;
        bus.wb_result  = $urandom;
    endtask

    initial begin
        model_reset();
        rand_results();
        @(negedge Clock);
        // Reset state
        drive(1, 0, 1, 5'd5, 5'd1, 1, 0, 32'h0000CAFE);
        check_val("rst_sel", bus.fwd_sel, 2'b00);
        check_val("rst_data", bus.rs2_fwd_data, 32'h0000CAFE);
        check_val("rst_en", bus.rs2_fwd_en, 1'b1);
        Reset = 1'b0;
        bus.Tick = 1'b0;
        advance();

        // EX forwarding
        issue(5'd5, 1, 0);
        bus.ex_result = 32'h00001234;
        drive(0, 0, 1, 5'd5, 5'd0, 0, 0, 32'h11111111);
        check_val("t1_sel", bus.fwd_sel, 2'b01);
        check_val("t1_data", bus.rs2_fwd_data, 32'h00001234);
        advance();

        // EX beats MEM beats WB
        issue(5'd5, 1, 0); issue(5'd5, 1, 0); issue(5'd5, 1, 0);
        drive(0, 0, 1, 5'd5, 5'd0, 0, 0, 32'h22222222);
        check_val("t2_ex_wins", bus.fwd_sel, 2'b01);
        drive(1, 0, 0, 5'd0, 5'd0, 0, 0, 32'h0);
        advance();
        bus.mem_result = 32'h0BADF00D;
        drive(0, 0, 1, 5'd5, 5'd0, 0, 0, 32'h33333333);
        check_val("t2_mem_sel", bus.fwd_sel, 2'b10);
        check_val("t2_mem_data", bus.rs2_fwd_data, 32'h0BADF00D);
        advance();

        // x0 never forwarded
        issue(5'd0, 1, 0);
        drive(0, 0, 1, 5'd0, 5'd0, 0, 0, 32'h0);
        check_val("t3_x0_sel", bus.fwd_sel, 2'b00);
        check_val("t3_x0_data", bus.rs2_fwd_data, 32'h0);
        advance();

        // Load-use: one bubble, then MEM forwarding
        issue(5'd7, 1, 1);
        drive(1, 0, 1, 5'd7, 5'd9, 1, 0, 32'h44444444);
        check_val("t4_stall", bus.stall, 1'b1);
        check_val("t4_en", bus.rs2_fwd_en, 1'b0);
        advance();
        bus.mem_result = 32'hDEADBEEF;
        drive(1, 0, 1, 5'd7, 5'd9, 1, 0, 32'h44444444);
        check_val("t4_sel", bus.fwd_sel, 2'b10);
        check_val("t4_data", bus.rs2_fwd_data, 32'hDEADBEEF);
        check_val("t4_unstall", bus.stall, 1'b0);
        advance();

        // Flush beats load-use; Tick=0 holds state
        issue(5'd7, 1, 1);
        drive(1, 1, 1, 5'd7, 5'd9, 1, 0, 32'h55555555);
        check_val("t5_no_stall", bus.stall, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 5'd7, 5'd9, 1, 1, 32'h66666666);
            check_val("t5_hold_sel", bus.fwd_sel, 2'b10);
            advance();
        end

        // Asynchronous reset while stalling
        issue(5'd7, 1, 1);
        drive(0, 0, 1, 5'd7, 5'd9, 1, 0, 32'h77777777);
        check_val("t6_pre_stall", bus.stall, 1'b1);
        #1 Reset = 1'b1;
        #1;
        check_val("t6_stall", bus.stall, 1'b0);
        check_val("t6_sel", bus.fwd_sel, 2'b00);
        check_val("t6_data", bus.rs2_fwd_data, 32'h77777777);
        model_reset();
        advance();
        Reset = 1'b0;
        drive(0, 0, 1, 5'd7, 5'd9, 1, 0, 32'h88888888);
        check_val("t6_cleared", bus.fwd_sel, 2'b00);
        advance();

        // Random traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rand_results();
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 12, $urandom_range(0, 9) < 9,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom);
            advance();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
